// File: rtl/cache_mem_arbiter.sv
// Main-memory port arbiter between I-cache and D-cache refill/write-back paths.
// One fixed-latency transaction at a time; D preferred with an I starvation bound.
module cache_mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int LINE_W     = 128,
  parameter int LATENCY    = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_done,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_done,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam int SC_W  = $clog2(STARVE_MAX + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t            state_q;
  logic              owner_d_q;
  logic              we_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [SC_W-1:0]   starve_cnt_q;
  logic              i_done_q, d_done_q;
  logic [LINE_W-1:0] i_rdata_q, d_rdata_q;
  logic              mem_en_q, mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [LINE_W-1:0] mem_wdata_q;
  logic              busy_q;
  logic              d_wins;

  always_comb begin
    d_wins = 1'b0;
    if (d_req && !(i_req && starve_cnt_q == SC_W'(STARVE_MAX)))
      d_wins = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_d_q    <= 1'b0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      starve_cnt_q <= '0;
      i_done_q     <= 1'b0;
      d_done_q     <= 1'b0;
      i_rdata_q    <= '0;
      d_rdata_q    <= '0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      busy_q       <= 1'b0;
    end else begin
      i_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      case (state_q)
        IDLE: begin
          if (i_req || d_req) begin
            // Command outputs are registered here so they appear exactly in ISSUE.
            state_q    <= ISSUE;
            busy_q     <= 1'b1;
            owner_d_q  <= d_wins;
            we_q       <= d_wins & d_we;
            mem_en_q   <= 1'b1;
            mem_we_q   <= d_wins & d_we;
            mem_addr_q <= d_wins ? d_addr : i_addr;
            if (d_wins && d_we)
              mem_wdata_q <= d_wdata;
            if (!d_wins || !i_req)
              starve_cnt_q <= '0;
            else if (starve_cnt_q != SC_W'(STARVE_MAX))
              starve_cnt_q <= starve_cnt_q + SC_W'(1);
          end else begin
            starve_cnt_q <= '0;
          end
        end
        ISSUE: begin
          cnt_q   <= CNT_W'(LATENCY);
          state_q <= WAIT;
        end
        WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            if (!we_q) begin
              if (owner_d_q) d_rdata_q <= mem_rdata;
              else           i_rdata_q <= mem_rdata;
            end
            if (owner_d_q) d_done_q <= 1'b1;
            else           i_done_q <= 1'b1;
            state_q <= RESP;
          end
        end
        RESP: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign i_done    = i_done_q;
  assign d_done    = d_done_q;
  assign i_rdata   = i_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: directed scenarios plus a randomized run against
// a transaction-schedule model; a LATENCY=1 instance covers the short-latency corner.
module tb_cache_mem_arbiter;
  localparam int LAT  = 5;
  localparam int SMAX = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0]  i_addr = '0, d_addr = '0;
  logic [127:0] d_wdata = '0, mem_rdata = '0;
  logic         i_done, d_done, mem_en, mem_we, busy;
  logic [127:0] i_rdata, d_rdata, mem_wdata;
  logic [31:0]  mem_addr;

  logic         l1_i_req = 1'b0, l1_d_req = 1'b0;
  logic [127:0] l1_mem_rdata = '0;
  logic         l1_i_done, l1_d_done, l1_mem_en, l1_mem_we, l1_busy;
  logic [127:0] l1_i_rdata, l1_d_rdata, l1_mem_wdata;
  logic [31:0]  l1_mem_addr;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  bit mem_const = 1'b0;
  int pend_c = -1000, l1_pend_c = -1000;
  logic [31:0] pend_a = '0, l1_pend_a = '0;

  cache_mem_arbiter #(.ADDR_W(32), .LINE_W(128), .LATENCY(LAT), .STARVE_MAX(SMAX)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(d_done), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  cache_mem_arbiter #(.ADDR_W(32), .LINE_W(128), .LATENCY(1), .STARVE_MAX(SMAX)) dut_l1 (
    .clk(clk), .reset(reset),
    .i_req(l1_i_req), .i_addr(i_addr), .i_done(l1_i_done), .i_rdata(l1_i_rdata),
    .d_req(l1_d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_done(l1_d_done), .d_rdata(l1_d_rdata),
    .mem_en(l1_mem_en), .mem_we(l1_mem_we), .mem_addr(l1_mem_addr), .mem_wdata(l1_mem_wdata),
    .mem_rdata(l1_mem_rdata), .busy(l1_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [127:0] memfun(input logic [31:0] a);
    return {a ^ 32'hA5A5_5A5A, ~a, a + 32'h1357_9BDF, {a[15:0], a[31:16]}};
  endfunction

  // Memory models: valid data exactly N cycles after the strobe, noise otherwise.
  always @(negedge clk) begin
    if (mem_en) begin pend_c = cyc; pend_a = mem_addr; end
    if (cyc == pend_c + LAT)
      mem_rdata = mem_const ? {4{32'hA5A5_A5A5}} : memfun(pend_a);
    else
      mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    if (l1_mem_en) begin l1_pend_c = cyc; l1_pend_a = l1_mem_addr; end
    if (cyc == l1_pend_c + 1)
      l1_mem_rdata = memfun(l1_pend_a);
    else
      l1_mem_rdata = {$urandom, $urandom, $urandom, $urandom};
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    tick; tick;
    total++;
    if ({mem_en, mem_we, i_done, d_done, busy} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl: got %b want 00000", {mem_en, mem_we, i_done, d_done, busy});
    end
    total++;
    if (mem_addr !== 32'h0 || mem_wdata !== 128'h0) begin
      bad++; $display("FAIL reset_bus: addr=%h wdata=%h want 0", mem_addr, mem_wdata);
    end
    total++;
    if (i_rdata !== 128'h0 || d_rdata !== 128'h0) begin
      bad++; $display("FAIL reset_rdata: i=%h d=%h want 0", i_rdata, d_rdata);
    end
    total++;
    if (dut.starve_cnt_q !== 3'd0) begin
      bad++; $display("FAIL reset_starve: got %0d want 0", dut.starve_cnt_q);
    end
    reset = 1'b1;
    tick;
  endtask

  task automatic test_single_i;
    mem_const = 1'b1;
    i_addr = 32'h100; i_req = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick;
      if (c == 1) begin
        total++;
        if (mem_en !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
          bad++; $display("FAIL single_issue: en=%b addr=%h we=%b want 1 100 0", mem_en, mem_addr, mem_we);
        end
      end
      total++;
      if (d_done !== 1'b0) begin bad++; $display("FAIL single_ddone c%0d: got %b want 0", c, d_done); end
      total++;
      if (i_done !== (c == 7)) begin bad++; $display("FAIL single_idone c%0d: got %b want %b", c, i_done, c == 7); end
      if (c == 7) begin
        total++;
        if (i_rdata !== {4{32'hA5A5_A5A5}}) begin
          bad++; $display("FAIL single_rdata: got %h want a5..a5", i_rdata);
        end
        i_req = 1'b0;
      end
      if (c == 8) begin
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL single_idle: busy=%b want 0", busy); end
      end
    end
    mem_const = 1'b0;
  endtask

  task automatic test_d_writeback;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2040; d_wdata = 128'h1234;
    for (int c = 1; c <= 8; c++) begin
      tick;
      if (c == 1) begin
        total++;
        if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h2040 || mem_wdata !== 128'h1234) begin
          bad++; $display("FAIL wb_issue: en=%b we=%b addr=%h wdata=%h want 1 1 2040 1234", mem_en, mem_we, mem_addr, mem_wdata);
        end
      end
      if (c == 2) begin
        total++;
        if (mem_en !== 1'b0 || mem_wdata !== 128'h0) begin
          bad++; $display("FAIL wb_strobe: en=%b wdata=%h want 0 0", mem_en, mem_wdata);
        end
      end
      total++;
      if (d_done !== (c == 7) || i_done !== 1'b0) begin
        bad++; $display("FAIL wb_done c%0d: d=%b i=%b want %b 0", c, d_done, i_done, c == 7);
      end
      if (c == 7) begin
        total++;
        if (d_rdata !== 128'h0) begin bad++; $display("FAIL wb_rdata: got %h want 0", d_rdata); end
        d_req = 1'b0; d_we = 1'b0;
      end
    end
  endtask

  task automatic test_simultaneous;
    i_req = 1'b1; i_addr = 32'h400;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300;
    for (int c = 1; c <= 16; c++) begin
      tick;
      total++;
      if (mem_en !== (c == 1 || c == 9)) begin
        bad++; $display("FAIL simul_en c%0d: got %b want %b", c, mem_en, c == 1 || c == 9);
      end
      if (c == 1 || c == 9) begin
        total++;
        if (mem_addr !== ((c == 1) ? 32'h300 : 32'h400)) begin
          bad++; $display("FAIL simul_addr c%0d: got %h want %h", c, mem_addr, (c == 1) ? 32'h300 : 32'h400);
        end
      end
      total++;
      if (d_done !== (c == 7) || i_done !== (c == 15)) begin
        bad++; $display("FAIL simul_done c%0d: d=%b i=%b want %b %b", c, d_done, i_done, c == 7, c == 15);
      end
      if (c == 7) begin
        total++;
        if (d_rdata !== memfun(32'h300)) begin bad++; $display("FAIL simul_drdata: got %h want %h", d_rdata, memfun(32'h300)); end
        d_req = 1'b0;
      end
      if (c == 15) begin
        total++;
        if (i_rdata !== memfun(32'h400)) begin bad++; $display("FAIL simul_irdata: got %h want %h", i_rdata, memfun(32'h400)); end
        i_req = 1'b0;
      end
    end
  endtask

  task automatic test_starvation;
    i_req = 1'b1; i_addr = 32'h500;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h600;
    for (int c = 1; c <= 40; c++) begin
      tick;
      total++;
      if (mem_en !== (c % 8 == 1)) begin bad++; $display("FAIL starve_en c%0d: got %b want %b", c, mem_en, c % 8 == 1); end
      if (c % 8 == 1) begin
        total++;
        if (mem_addr !== ((c == 33) ? 32'h500 : 32'h600)) begin
          bad++; $display("FAIL starve_owner c%0d: addr=%h want %h", c, mem_addr, (c == 33) ? 32'h500 : 32'h600);
        end
      end
      total++;
      if (d_done !== (c % 8 == 7 && c < 32) || i_done !== (c == 39)) begin
        bad++; $display("FAIL starve_done c%0d: d=%b i=%b", c, d_done, i_done);
      end
      if (c == 26) begin
        total++;
        if (dut.starve_cnt_q !== 3'd4) begin bad++; $display("FAIL starve_cnt_max: got %0d want 4", dut.starve_cnt_q); end
      end
      if (c == 34) begin
        total++;
        if (dut.starve_cnt_q !== 3'd0) begin bad++; $display("FAIL starve_cnt_clear: got %0d want 0", dut.starve_cnt_q); end
      end
      if (c == 39) begin i_req = 1'b0; d_req = 1'b0; end
      if (c == 40) begin
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL starve_idle: busy=%b want 0", busy); end
      end
    end
  endtask

  task automatic test_reset_mid_wait;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h700;
    tick; tick; tick;
    reset = 1'b0;
    tick;
    total++;
    if ({mem_en, mem_we, i_done, d_done, busy} !== 5'b0 || mem_addr !== 32'h0 || mem_wdata !== 128'h0) begin
      bad++; $display("FAIL rst_mid_ctrl: ctrl=%b addr=%h want 0", {mem_en, mem_we, i_done, d_done, busy}, mem_addr);
    end
    total++;
    if (i_rdata !== 128'h0 || d_rdata !== 128'h0) begin
      bad++; $display("FAIL rst_mid_rdata: i=%h d=%h want 0", i_rdata, d_rdata);
    end
    reset = 1'b1; d_req = 1'b0;
    for (int c = 5; c <= 12; c++) begin
      tick;
      total++;
      if (d_done !== 1'b0 || busy !== 1'b0 || d_rdata !== 128'h0) begin
        bad++; $display("FAIL rst_mid_quiet c%0d: done=%b busy=%b rdata=%h want 0", c, d_done, busy, d_rdata);
      end
    end
    d_req = 1'b1; d_addr = 32'h740;
    for (int c = 1; c <= 8; c++) begin
      tick;
      total++;
      if (d_done !== (c == 7)) begin bad++; $display("FAIL rst_mid_redo c%0d: got %b want %b", c, d_done, c == 7); end
      if (c == 7) begin
        total++;
        if (d_rdata !== memfun(32'h740)) begin bad++; $display("FAIL rst_mid_rdata2: got %h want %h", d_rdata, memfun(32'h740)); end
        d_req = 1'b0;
      end
    end
  endtask

  task automatic test_latency1;
    l1_i_req = 1'b1; i_addr = 32'h800;
    for (int c = 1; c <= 4; c++) begin
      tick;
      total++;
      if (l1_mem_en !== (c == 1)) begin bad++; $display("FAIL lat1_en c%0d: got %b want %b", c, l1_mem_en, c == 1); end
      if (c == 1) begin
        total++;
        if (l1_mem_addr !== 32'h800) begin bad++; $display("FAIL lat1_addr: got %h want 800", l1_mem_addr); end
      end
      total++;
      if (l1_i_done !== (c == 3)) begin bad++; $display("FAIL lat1_done c%0d: got %b want %b", c, l1_i_done, c == 3); end
      total++;
      if (l1_busy !== (c != 4)) begin bad++; $display("FAIL lat1_busy c%0d: got %b want %b", c, l1_busy, c != 4); end
      if (c == 3) begin
        total++;
        if (l1_i_rdata !== memfun(32'h800)) begin bad++; $display("FAIL lat1_rdata: got %h want %h", l1_i_rdata, memfun(32'h800)); end
        l1_i_req = 1'b0;
      end
    end
  endtask

  // Model: a grant at idle cycle g issues at g+1, completes at g+LAT+2, frees at g+LAT+3.
  task automatic test_random;
    int g = -100;
    int st = 0;
    bit od = 1'b0, owe = 1'b0;
    logic [31:0] oaddr = '0;
    logic [127:0] owd = '0, ei = '0, ed = '0;
    bit e_en, e_id, e_dd, e_busy;
    reset = 1'b0; i_req = 1'b0; d_req = 1'b0;
    tick;
    reset = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      if (k > 0) tick;
      e_en   = (k == g + 1);
      e_id   = (k == g + LAT + 2) && !od;
      e_dd   = (k == g + LAT + 2) && od;
      e_busy = (k > g) && (k < g + LAT + 3);
      if (e_id) ei = memfun(oaddr);
      if (e_dd && !owe) ed = memfun(oaddr);
      total++;
      if (mem_en !== e_en || busy !== e_busy) begin
        bad++; $display("FAIL rnd_ctrl k%0d: en=%b busy=%b want %b %b", k, mem_en, busy, e_en, e_busy);
      end
      total++;
      if (mem_addr !== (e_en ? oaddr : 32'h0) || mem_we !== (e_en && owe)) begin
        bad++; $display("FAIL rnd_cmd k%0d: addr=%h we=%b want %h %b", k, mem_addr, mem_we, e_en ? oaddr : 32'h0, e_en && owe);
      end
      if (!e_en || owe) begin
        total++;
        if (mem_wdata !== ((e_en && owe) ? owd : 128'h0)) begin
          bad++; $display("FAIL rnd_wdata k%0d: got %h want %h", k, mem_wdata, (e_en && owe) ? owd : 128'h0);
        end
      end
      total++;
      if (i_done !== e_id || d_done !== e_dd) begin
        bad++; $display("FAIL rnd_done k%0d: i=%b d=%b want %b %b", k, i_done, d_done, e_id, e_dd);
      end
      total++;
      if (i_rdata !== ei || d_rdata !== ed) begin
        bad++; $display("FAIL rnd_rdata k%0d: i=%h d=%h want %h %h", k, i_rdata, d_rdata, ei, ed);
      end
      if (e_id) i_req = 1'b0;
      else if (!i_req && $urandom_range(3) == 0) begin
        i_req = 1'b1; i_addr = $urandom;
      end
      if (e_dd) d_req = 1'b0;
      else if (!d_req && $urandom_range(3) == 0) begin
        d_req = 1'b1; d_we = 1'($urandom_range(1)); d_addr = $urandom;
        d_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      if (k >= g + LAT + 3) begin
        if (i_req || d_req) begin
          od = d_req && !(i_req && st == SMAX);
          if (!od || !i_req) st = 0;
          else if (st < SMAX) st = st + 1;
          g = k;
          owe = od && d_we;
          oaddr = od ? d_addr : i_addr;
          owd = d_wdata;
        end else begin
          st = 0;
        end
      end
    end
    i_req = 1'b0; d_req = 1'b0;
  endtask

  initial begin
    test_reset;
    test_single_i;
    test_d_writeback;
    test_simultaneous;
    test_starvation;
    test_reset_mid_wait;
    test_latency1;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
# cache_mem_arbiter

Arbitrates the single main-memory port between the instruction-cache and data-cache refill/write-back paths of the pipelined core. It sits below both caches: a miss (`ihit`/`dhit` low) raises a request here, and the arbiter sequences one fixed-latency memory transaction at a time. It returns line data with a one-cycle `done` pulse. D-side is preferred, with a starvation bound guaranteeing I-side progress.

## Interface
- `ADDR_W`, 32, byte address width
- `LINE_W`, 128, cache line width in bits
- `LATENCY`, 5, memory cycles from `mem_en` to valid `mem_rdata`; must be at least 1
- `STARVE_MAX`, 4, max consecutive D grants while I waits

- `clk`  in  1  clock, rising edge
- `reset`  in  1  reset, synchronous, active-low
- `i_req`  in  1  I-cache miss request; level, held until `i_done`
- `i_addr`  in  ADDR_W  I line address; stable while `i_req`
- `i_done`  out  1  one-cycle completion pulse
- `i_rdata`  out  LINE_W  I refill line; valid when `i_done`, held afterwards
- `d_req`  in  1  D-cache request; level, held until `d_done`
- `d_we`  in  1  1 = line write-back, 0 = refill
- `d_addr`  in  ADDR_W  D line address
- `d_wdata`  in  LINE_W  write-back line
- `d_done`  out  1  one-cycle completion pulse
- `d_rdata`  out  LINE_W  D refill line; valid when `d_done` on reads, held afterwards
- `mem_en`  out  1  memory command strobe, one cycle per transaction
- `mem_we`  out  1  write command
- `mem_addr`  out  ADDR_W  command address
- `mem_wdata`  out  LINE_W  write data
- `mem_rdata`  in  LINE_W  read data; valid exactly `LATENCY` cycles after `mem_en`
- `busy`  out  1  high whenever state is not IDLE

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE → ISSUE** when any request is sampled. The arbiter latches the owner, address, `we` and `wdata` of the winner.
- **Arbitration** in IDLE:
  - Only one request pending: that requester wins.
  - Both pending: D wins, unless `starve_cnt == STARVE_MAX`, in which case I wins.
- **`starve_cnt`** (saturating, width clog2(STARVE_MAX+1)):
  - Increments on a D grant while `i_req` is high.
  - Clears on an I grant.
  - Clears in IDLE when `i_req` is low.
- **ISSUE** lasts one cycle:
  - `mem_en` = 1; `mem_we`, `mem_addr` and `mem_wdata` (if write) are driven from the latched values.
  - Loads the latency counter with `LATENCY`, then goes to WAIT.
- **WAIT**:
  - The counter decrements each cycle.
  - In the cycle where the counter equals 1 (`mem_rdata` valid), a read captures `mem_rdata` into the owner's rdata register.
  - Then goes to RESP.
- **RESP** lasts one cycle: the owner's `done` = 1, then the FSM goes to IDLE.
- **Writes** follow the same sequence and latency; `d_rdata` is not updated on a write.
- **Output values outside ISSUE**: `mem_en`, `mem_we`, `mem_addr` and `mem_wdata` are 0.
- **Requester obligation**: deassert `req` in the cycle after `done`. A request held high through IDLE is treated as a new request.
- Only one transaction is outstanding at a time; there is no pipelining.

## Timing
- **Reset**, when `reset` is sampled 0:
  - State goes to IDLE.
  - All outputs, `starve_cnt`, the latency counter and both rdata registers go to 0.
  - Reset overrides all other events.
  - **Reset mid-transaction**: the transaction is aborted, no `done` is issued, and the late `mem_rdata` is ignored.
- **Transaction cycle numbering** (cycle 0 = `req` first sampled high in IDLE):
  - Cycle 1: ISSUE (`mem_en` = 1).
  - Cycles 2..LATENCY: WAIT.
  - Cycle LATENCY+1: data captured (still WAIT).
  - Cycle LATENCY+2: RESP, `done` = 1.
  - Cycle LATENCY+3: IDLE.
- **Latency figures**:
  - Request-to-done latency is LATENCY+2.
  - Back-to-back grant spacing is LATENCY+3; with default `LATENCY` = 5, that is 8 cycles.
  - With `LATENCY` = 1: ISSUE at cycle 1, WAIT (capture) at cycle 2, `done` at cycle 3.
- **Simultaneous events**:
  - A request arriving during ISSUE, WAIT or RESP waits for IDLE.
  - A loser's request is held and arbitrated at the next IDLE.
- `busy` = 0 only in IDLE.

## Test plan
- **Single I refill**:
  - Stimulus: `i_req` = 1, `i_addr` = 0x100 at cycle 0, `LATENCY` = 5, memory returns 0xA5…A5.
  - Required: `mem_en` = 1 with `mem_addr` = 0x100 and `mem_we` = 0 at cycle 1; `i_done` = 1 with `i_rdata` = 0xA5…A5 at cycle 7; `d_done` stays 0.
- **D write-back**:
  - Stimulus: `d_req` = 1, `d_we` = 1, `d_addr` = 0x2040, `d_wdata` = 0x1234.
  - Required: `mem_we` = 1 with `mem_wdata` = 0x1234 at cycle 1; `d_done` at cycle 7; `d_rdata` unchanged (0).
- **Simultaneous requests** at cycle 0:
  - Required: D is issued at cycle 1 and `d_done` fires at cycle 7; I is issued at cycle 9 and `i_done` fires at cycle 15.
- **Starvation bound**:
  - Stimulus: `i_req` held high; `d_req` reasserted immediately after every `d_done`.
  - Required: four D grants, then the fifth grant goes to I (ISSUE at cycle 33); `starve_cnt` returns to 0.
- **Reset mid-WAIT**:
  - Stimulus: `reset` = 0 at cycle 3 of a D read.
  - Required: all outputs are 0 in the next cycle; no `d_done` pulse; state is IDLE; a new request then completes normally.
- **`LATENCY` = 1 corner**:
  - Required: `mem_en` at cycle 1, `mem_rdata` captured at cycle 2, `done` at cycle 3, IDLE at cycle 4.
